// File: rtl/register_file_sb_if.sv
// Bus bundle for register_file_sb: two read ports, one write-back port,
// the scoreboard reservation port and the hazard-error flag.
interface register_file_sb_if #(
    parameter int DATA_W   = 8,
    parameter int NUM_REGS = 4
);
    localparam int ADDR_W = $clog2(NUM_REGS);

    logic                rd_a_en;
    logic [ADDR_W-1:0]   rd_a_addr;
    logic [DATA_W-1:0]   rd_a_data;
    logic                rd_a_valid;
    logic                rd_a_stale;

    logic                rd_b_en;
    logic [ADDR_W-1:0]   rd_b_addr;
    logic [DATA_W-1:0]   rd_b_data;
    logic                rd_b_valid;
    logic                rd_b_stale;

    logic                wr_en;
    logic [ADDR_W-1:0]   wr_addr;
    logic [DATA_W-1:0]   wr_data;

    logic                rsv_en;
    logic [ADDR_W-1:0]   rsv_addr;

    logic                err_clr;
    logic [NUM_REGS-1:0] busy;
    logic                err;

    // Decode/control side
    modport master (
        output rd_a_en, rd_a_addr, rd_b_en, rd_b_addr,
        output wr_en, wr_addr, wr_data, rsv_en, rsv_addr, err_clr,
        input  rd_a_data, rd_a_valid, rd_a_stale,
        input  rd_b_data, rd_b_valid, rd_b_stale,
        input  busy, err
    );

    // Register file side
    modport slave (
        input  rd_a_en, rd_a_addr, rd_b_en, rd_b_addr,
        input  wr_en, wr_addr, wr_data, rsv_en, rsv_addr, err_clr,
        output rd_a_data, rd_a_valid, rd_a_stale,
        output rd_b_data, rd_b_valid, rd_b_stale,
        output busy, err
    );
endinterface

// File: rtl/register_file_sb.sv
// 2-read/1-write register file with registered read ports, optional
// write-to-read bypass, per-register busy scoreboard and sticky hazard flag.
module register_file_sb #(
    parameter int DATA_W   = 8,
    parameter int NUM_REGS = 4,
    parameter int BYPASS   = 1
) (
    input logic               reg_clk,
    input logic               reg_rst,
    register_file_sb_if.slave bus
);
    localparam int ADDR_W = $clog2(NUM_REGS);
    // One extra bit so NUM_REGS itself is representable when it is a power of two
    localparam logic [ADDR_W:0] LIMIT = (ADDR_W + 1)'(NUM_REGS);

    function automatic logic in_range(input logic [ADDR_W-1:0] addr);
        return {1'b0, addr} < LIMIT;
    endfunction

    // Returns {valid, stale, data} for one read port as it will appear next cycle
    function automatic logic [DATA_W+1:0] read_port(
        input logic              en,
        input logic [ADDR_W-1:0] addr,
        input logic [DATA_W-1:0] stored,
        input logic              wr_hit,
        input logic [DATA_W-1:0] wdata,
        input logic              pending
    );
        logic              valid;
        logic              stale;
        logic [DATA_W-1:0] data;
        valid = en && in_range(addr);
        stale = 1'b0;
        data  = '0;
        if (valid) begin
            data  = (BYPASS != 0 && wr_hit) ? wdata : stored;
            stale = pending;
        end
        return {valid, stale, data};
    endfunction

    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_wr;
    logic [NUM_REGS-1:0] busy_d;
    logic                err_q;
    logic                err_set;
    logic                wr_ok;
    logic                rsv_ok;

    logic [DATA_W-1:0]   rd_a_data_p0, rd_a_data_p1;
    logic                rd_a_valid_p0, rd_a_valid_p1;
    logic                rd_a_stale_p0, rd_a_stale_p1;
    logic [DATA_W-1:0]   rd_b_data_p0, rd_b_data_p1;
    logic                rd_b_valid_p0, rd_b_valid_p1;
    logic                rd_b_stale_p0, rd_b_stale_p1;

    // Scoreboard update (write clears first, then reservation sets) and read-port next values
    always_comb begin
        wr_ok   = bus.wr_en && in_range(bus.wr_addr);
        rsv_ok  = bus.rsv_en && in_range(bus.rsv_addr);
        busy_wr = busy_q;
        if (wr_ok) begin
            busy_wr[bus.wr_addr] = 1'b0;
        end
        busy_d  = busy_wr;
        err_set = 1'b0;
        if (rsv_ok) begin
            // A register written this cycle has already been released, so re-reserving it is legal
            err_set              = busy_wr[bus.rsv_addr];
            busy_d[bus.rsv_addr] = 1'b1;
        end
        {rd_a_valid_p0, rd_a_stale_p0, rd_a_data_p0} = read_port(
            bus.rd_a_en, bus.rd_a_addr, regs[bus.rd_a_addr],
            wr_ok && (bus.wr_addr == bus.rd_a_addr), bus.wr_data, busy_wr[bus.rd_a_addr]);
        {rd_b_valid_p0, rd_b_stale_p0, rd_b_data_p0} = read_port(
            bus.rd_b_en, bus.rd_b_addr, regs[bus.rd_b_addr],
            wr_ok && (bus.wr_addr == bus.rd_b_addr), bus.wr_data, busy_wr[bus.rd_b_addr]);
    end

    // Register array: write-back port, cleared on reset
    always_ff @(posedge reg_clk) begin
        if (reg_rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_ok) begin
            regs[bus.wr_addr] <= bus.wr_data;
        end
    end

    // Busy vector and sticky hazard flag; a new hazard outranks err_clr
    always_ff @(posedge reg_clk) begin
        if (reg_rst) begin
            busy_q <= '0;
            err_q  <= 1'b0;
        end else begin
            busy_q <= busy_d;
            if (err_set) begin
                err_q <= 1'b1;
            end else if (bus.err_clr) begin
                err_q <= 1'b0;
            end
        end
    end

    // Read-port output registers; requests seen during reset are dropped
    always_ff @(posedge reg_clk) begin
        if (reg_rst) begin
            rd_a_data_p1  <= '0;
            rd_a_valid_p1 <= 1'b0;
            rd_a_stale_p1 <= 1'b0;
            rd_b_data_p1  <= '0;
            rd_b_valid_p1 <= 1'b0;
            rd_b_stale_p1 <= 1'b0;
        end else begin
            rd_a_data_p1  <= rd_a_data_p0;
            rd_a_valid_p1 <= rd_a_valid_p0;
            rd_a_stale_p1 <= rd_a_stale_p0;
            rd_b_data_p1  <= rd_b_data_p0;
            rd_b_valid_p1 <= rd_b_valid_p0;
            rd_b_stale_p1 <= rd_b_stale_p0;
        end
    end

    assign bus.rd_a_data  = rd_a_data_p1;
    assign bus.rd_a_valid = rd_a_valid_p1;
    assign bus.rd_a_stale = rd_a_stale_p1;
    assign bus.rd_b_data  = rd_b_data_p1;
    assign bus.rd_b_valid = rd_b_valid_p1;
    assign bus.rd_b_stale = rd_b_stale_p1;
    assign bus.busy       = busy_q;
    assign bus.err        = err_q;
endmodule
